// File: rtl/fp_div_seq32.sv
// rtl/fp_div_seq32.sv - sequencer driving an fpDivide32nr-style divider behind request/response handshakes
//
// Optional build macro: DIV_TIMEOUT_EN adds a WAIT-state watchdog (TMO cycles).
//
// Parameters:
//   DONE_MASK  cycles after div_ld during which div_done is ignored
//   TMO        WAIT-state cycle limit (used only with DIV_TIMEOUT_EN)
// Ports:
//   clk, rst                 clock (rising edge) and synchronous active-low reset
//   ce                       clock enable; low freezes all state and masks div_ld
//   req_valid/req_ready      request handshake carrying req_a, req_b, req_tag
//   div_ld, div_a, div_b     divider start pulse and operands
//   div_done, div_o,
//   div_overflow,
//   div_underflow            divider completion and result
//   rsp_valid/rsp_ready      response handshake carrying rsp_o, rsp_tag,
//                            rsp_flags = {timeout, overflow, underflow}

module fp_div_seq32 #(
    parameter int DONE_MASK = 3,
    parameter int TMO       = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [3:0]  req_tag,
    output logic        div_ld,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic        div_done,
    input  logic [31:0] div_o,
    input  logic        div_overflow,
    input  logic        div_underflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_o,
    output logic [3:0]  rsp_tag,
    output logic [2:0]  rsp_flags
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MASK,
        WAIT,
        HOLD
    } state_t;

    localparam int MW = (DONE_MASK > 0) ? $clog2(DONE_MASK + 1) : 1;
    localparam logic [MW-1:0] MASK_LAST = MW'((DONE_MASK > 0) ? DONE_MASK - 1 : 0);

    state_t        state;
    logic [MW-1:0] mask_cnt;
    logic          ld_r;
    logic [1:0]    flags_r;

    // The start pulse is registered but gated by ce so a frozen LOAD never
    // presents a stretched pulse to the divider.
    assign div_ld = ld_r & ce;

`ifdef DIV_TIMEOUT_EN
    localparam int TW = (TMO > 0) ? $clog2(TMO + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_flag;

    assign rsp_flags = {tmo_flag, flags_r};
`else
    logic unused_tmo;

    assign unused_tmo = (TMO != 0);
    assign rsp_flags  = {1'b0, flags_r};
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            ld_r      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_o     <= '0;
            rsp_tag   <= '0;
            flags_r   <= '0;
            div_a     <= '0;
            div_b     <= '0;
            mask_cnt  <= '0;
`ifdef DIV_TIMEOUT_EN
            tmo_cnt   <= '0;
            tmo_flag  <= 1'b0;
`endif
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        div_a     <= req_a;
                        div_b     <= req_b;
                        rsp_tag   <= req_tag;
                        req_ready <= 1'b0;
                        ld_r      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    ld_r     <= 1'b0;
                    mask_cnt <= '0;
`ifdef DIV_TIMEOUT_EN
                    tmo_cnt  <= '0;
`endif
                    state    <= (DONE_MASK == 0) ? WAIT : MASK;
                end
                MASK: begin
                    // The divider's done output may still be high from the
                    // previous operation; sit out that window.
                    if (mask_cnt == MASK_LAST) begin
                        state <= WAIT;
                    end else begin
                        mask_cnt <= mask_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (div_done) begin
                        rsp_o     <= div_o;
                        flags_r   <= {div_overflow, div_underflow};
                        rsp_valid <= 1'b1;
`ifdef DIV_TIMEOUT_EN
                        tmo_flag  <= 1'b0;
`endif
                        state     <= HOLD;
                    end
`ifdef DIV_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        rsp_o     <= 32'h7FC0_0000;
                        flags_r   <= 2'b00;
                        tmo_flag  <= 1'b1;
                        rsp_valid <= 1'b1;
                        state     <= HOLD;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                HOLD: begin
                    // Returning to IDLE first keeps a back-to-back request
                    // from being accepted in the handshake cycle.
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_seq32.sv
// tb/tb_fp_div_seq32.sv - scoreboard bench for fp_div_seq32 with a scripted divider model

module tb_fp_div_seq32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [3:0]  req_tag = '0;
    logic        div_ld;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        div_done;
    logic [31:0] div_o;
    logic        div_overflow;
    logic        div_underflow;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_o;
    logic [3:0]  rsp_tag;
    logic [2:0]  rsp_flags;

    fp_div_seq32 dut (
        .clk           (clk),
        .rst           (rst),
        .ce            (ce),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_tag       (req_tag),
        .div_ld        (div_ld),
        .div_a         (div_a),
        .div_b         (div_b),
        .div_done      (div_done),
        .div_o         (div_o),
        .div_overflow  (div_overflow),
        .div_underflow (div_underflow),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_o         (rsp_o),
        .rsp_tag       (rsp_tag),
        .rsp_flags     (rsp_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Divider stand-in: bit k of pat drives done for the (k+1)-th edge after ld.
    logic [127:0] pat = '0;
    logic [31:0]  m_o = '0;
    logic         m_ov = 1'b0;
    logic         m_un = 1'b0;
    logic         m_active = 1'b0;
    int           m_age = 0;

    always @(posedge clk) begin
        if (div_ld) begin
            m_active <= 1'b1;
            m_age    <= 0;
        end else if (m_active && m_age < 200) begin
            m_age <= m_age + 1;
        end
    end

    assign div_done      = m_active && (m_age < 128) && pat[m_age[6:0]];
    assign div_o         = m_o;
    assign div_overflow  = m_ov;
    assign div_underflow = m_un;

    typedef struct {
        logic [31:0] o;
        logic [3:0]  tag;
        logic [2:0]  fl;
        int          at;
    } rsp_t;

    typedef struct {
        int          at;
        logic [31:0] a;
        logic [31:0] b;
    } ld_t;

    rsp_t exp_q[$];
    ld_t  ld_q[$];
    int   acc_q[$];

    int n_cmp = 0;
    int n_fail = 0;
    int hang_cnt = 0;
    int hang_seen = 0;
    int chk_rst_cyc = -1;
    bit end_req = 1'b0;
    bit end_ack = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    rsp_t mon_e;
    rsp_t mon_cur;
    ld_t  mon_l;
    bit   prev_v = 1'b0;

    always @(negedge clk) begin
        if (cyc == chk_rst_cyc) begin
            chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
            chk("rst_div_ld", {31'b0, div_ld}, 32'd0);
            chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
            chk("rst_rsp_o", rsp_o, 32'd0);
            chk("rst_rsp_tag", {28'b0, rsp_tag}, 32'd0);
            chk("rst_rsp_flags", {29'b0, rsp_flags}, 32'd0);
            chk("rst_div_a", div_a, 32'd0);
            chk("rst_div_b", div_b, 32'd0);
        end
        if (hang_cnt != hang_seen) begin
            chk("wait_bound", hang_cnt, hang_seen);
            hang_seen = hang_cnt;
        end
        if (div_ld) begin
            if (ld_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL ld_pulse: got div_ld high at cycle %0d expected none", cyc);
            end else begin
                mon_l = ld_q.pop_front();
                chk("ld_cycle", cyc, mon_l.at);
                chk("div_a", div_a, mon_l.a);
                chk("div_b", div_b, mon_l.b);
            end
        end
        if (rsp_valid) begin
            chk("req_ready_in_hold", {31'b0, req_ready}, 32'd0);
            if (!prev_v) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rsp_valid at cycle %0d expected none", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_latency", cyc, mon_e.at);
                    chk("rsp_o", rsp_o, mon_e.o);
                    chk("rsp_tag", {28'b0, rsp_tag}, {28'b0, mon_e.tag});
                    chk("rsp_flags", {29'b0, rsp_flags}, {29'b0, mon_e.fl});
                    mon_cur = mon_e;
                end
            end else begin
                chk("hold_rsp_o", rsp_o, mon_cur.o);
                chk("hold_rsp_tag", {28'b0, rsp_tag}, {28'b0, mon_cur.tag});
                chk("hold_rsp_flags", {29'b0, rsp_flags}, {29'b0, mon_cur.fl});
            end
        end
        prev_v = rsp_valid;
        if (req_valid && req_ready && ce && rst && acc_q.size() != 0) begin
            chk("accept_cycle", cyc + 1, acc_q.pop_front());
        end
        if (end_req && !end_ack) begin
            chk("rsp_left", exp_q.size(), 32'd0);
            chk("ld_left", ld_q.size(), 32'd0);
            end_ack = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 300) begin
            tick();
            n++;
        end
        if (!req_ready) hang_cnt++;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || !req_ready) && n < 300) begin
            tick();
            n++;
        end
        if (exp_q.size() != 0 || !req_ready) hang_cnt++;
    endtask

    // Accepts at the next edge; lat = cycles from acceptance to rsp_valid.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                         input logic [31:0] o, input logic ov, input logic un,
                         input logic [127:0] p, input int lat);
        wait_ready();
        pat       = p;
        m_o       = o;
        m_ov      = ov;
        m_un      = un;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        ld_q.push_back('{cyc + 1, a, b});
        exp_q.push_back('{o, tag, {1'b0, ov, un}, cyc + 1 + lat});
        tick();
        req_valid = 1'b0;
    endtask

    logic [127:0] p;
    int           acc;
    int           n;

    initial begin
        rst = 1'b0;
        repeat (3) tick();
        chk_rst_cyc = cyc;
        tick();
        rst = 1'b1;
        tick();

        // 6.0 / 2.0, done six edges after ld
        p = '0; p[5] = 1'b1;
        issue(32'h40C0_0000, 32'h4000_0000, 4'd5, 32'h4040_0000, 1'b0, 1'b0, p, 7);
        wait_idle();

        // done held through the mask window, then low, then at the 8th edge
        p = '0; p[0] = 1'b1; p[1] = 1'b1; p[2] = 1'b1; p[7] = 1'b1;
        issue(32'h4110_0000, 32'h4040_0000, 4'd6, 32'h4040_0000, 1'b0, 1'b0, p, 9);
        wait_idle();

        // overflow, done ready on the first WAIT edge (minimum latency)
        p = '1; p[2:0] = 3'b000;
        issue(32'h7F00_0000, 32'h3E80_0000, 4'd1, 32'h7F80_0000, 1'b1, 1'b0, p, 5);
        wait_idle();

        // underflow to zero
        p = '0; p[4] = 1'b1;
        issue(32'h0080_0000, 32'h5F00_0000, 4'd2, 32'h0000_0000, 1'b0, 1'b1, p, 6);
        wait_idle();

        // response stalled for 10 cycles with a request pending
        rsp_ready = 1'b0;
        p = '0; p[5] = 1'b1;
        issue(32'h3F80_0000, 32'h4000_0000, 4'd3, 32'h3F00_0000, 1'b0, 1'b0, p, 7);
        n = 0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        if (!rsp_valid) hang_cnt++;
        req_valid = 1'b1;
        req_a     = 32'h4040_0000;
        req_b     = 32'h3F80_0000;
        req_tag   = 4'd9;
        repeat (10) tick();
        rsp_ready = 1'b1;
        acc_q.push_back(cyc + 2);
        issue(32'h4040_0000, 32'h3F80_0000, 4'd9, 32'h4040_0000, 1'b0, 1'b0, p, 7);
        wait_idle();

        // reset in WAIT; the stale done arrives later while idle
        wait_ready();
        pat = '0; pat[30] = 1'b1;
        m_o = 32'h1234_5678;
        req_valid = 1'b1;
        req_a     = 32'h4120_0000;
        req_b     = 32'h4000_0000;
        req_tag   = 4'd8;
        ld_q.push_back('{cyc + 1, 32'h4120_0000, 32'h4000_0000});
        tick();
        req_valid = 1'b0;
        acc = cyc;
        while (cyc < acc + 8) tick();
        rst = 1'b0;
        chk_rst_cyc = cyc + 1;
        tick();
        rst = 1'b1;
        repeat (30) tick();
        p = '0; p[5] = 1'b1;
        issue(32'h40A0_0000, 32'h4000_0000, 4'd7, 32'h4020_0000, 1'b0, 1'b0, p, 7);
        wait_idle();

        // ce toggling every other cycle: 1.0 / 4.0
        wait_ready();
        pat = '1;
        m_o = 32'h3E80_0000;
        m_ov = 1'b0;
        m_un = 1'b0;
        req_valid = 1'b1;
        req_a     = 32'h3F80_0000;
        req_b     = 32'h4080_0000;
        req_tag   = 4'd4;
        acc = cyc + 1;
        ld_q.push_back('{acc + 1, 32'h3F80_0000, 32'h4080_0000});
        exp_q.push_back('{32'h3E80_0000, 4'd4, 3'b000, acc + 10});
        tick();
        req_valid = 1'b0;
        ce = 1'b0;
        repeat (24) begin
            tick();
            ce = ~ce;
        end
        ce = 1'b1;
        wait_idle();

`ifdef DIV_TIMEOUT_EN
        // divider never answers
        wait_ready();
        pat = '0;
        req_valid = 1'b1;
        req_a     = 32'h4000_0000;
        req_b     = 32'h4000_0000;
        req_tag   = 4'd10;
        ld_q.push_back('{cyc + 1, 32'h4000_0000, 32'h4000_0000});
        exp_q.push_back('{32'h7FC0_0000, 4'd10, 3'b100, cyc + 1 + 2 + 3 + 63});
        tick();
        req_valid = 1'b0;
        wait_idle();
`endif

        end_req = 1'b1;
        n = 0;
        while (!end_ack && n < 10) begin
            tick();
            n++;
        end
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
